// File: rtl/pack_pkg.sv
// ------------------------------------------------------------------------
// pack_pkg : constants and types shared by the PLC TX framer and RX side. rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package pack_pkg;

  localparam int cPREA_LEN = 128;

  // Bit 0 is transmitted first.
  localparam logic [cPREA_LEN-1:0] cPREAMBLE = 128'h3A94_E1C7_5B02_F86D_9C4B_71E8_A53F_0D26;

  localparam logic [4:0] cSYM_ONE  = 5'b01111;
  localparam logic [4:0] cSYM_ZERO = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREA = 2'd1,
    PAY  = 2'd2,
    GAP  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pack_sym_map.sv
// ------------------------------------------------------------------------
// pack_sym_map : hard bit to 5-bit soft-decision symbol mapper. rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module pack_sym_map
  import pack_pkg::*;
#(
  parameter logic [4:0] SYM_ONE  = cSYM_ONE,
  parameter logic [4:0] SYM_ZERO = cSYM_ZERO
) (
  input  logic       bit_i,
  output logic [4:0] sym_o
);

  assign sym_o = bit_i ? SYM_ONE : SYM_ZERO;

endmodule

`default_nettype wire

// File: rtl/pack_framer.sv
// ------------------------------------------------------------------------
// pack_framer : TX framer emitting preamble, PAYLOAD_LEN bits, then a gap. rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module pack_framer
  import pack_pkg::*;
#(
  parameter int         PREA_LEN    = cPREA_LEN,
  parameter int         PAYLOAD_LEN = 1024,
  parameter int         GAP_LEN     = 16,
  parameter logic [4:0] SYM_ONE     = cSYM_ONE,
  parameter logic [4:0] SYM_ZERO    = cSYM_ZERO
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       istart,
  input  logic       idat,
  input  logic       ival,
  output logic       ordy,
  input  logic       irdy,
  output logic       oval,
  output logic       osop,
  output logic       oeop,
  output logic [4:0] odat,
  output logic       obusy
);

  localparam int PCW = $clog2(PREA_LEN + 1);
  localparam int DCW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int GCW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [PCW-1:0] PREA_END = PCW'(PREA_LEN);
  localparam logic [DCW-1:0] PAY_LAST = DCW'(PAYLOAD_LEN - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_e         state_q;
  logic [PCW-1:0] pcnt_q;
  logic [DCW-1:0] dcnt_q;
  logic [GCW-1:0] gcnt_q;
  logic           oval_q;
  logic           osop_q;
  logic           oeop_q;
  logic [4:0]     odat_q;

  logic       out_acc;
  logic       in_acc;
  logic       pay_last;
  logic       prea_bit;
  logic       ld_bit;
  logic [4:0] ld_sym;

  assign out_acc  = oval_q & irdy;
  assign pay_last = (dcnt_q == PAY_LAST);

  // Once the last payload bit is loaded (oeop_q set) upstream is throttled.
  assign ordy = (((state_q == PAY) & ~oeop_q) |
                 ((state_q == PREA) & (pcnt_q == PREA_END))) & (~oval_q | irdy);
  assign in_acc = ival & ordy;

  // pcnt is 0 in IDLE, so this also supplies preamble[0] for the first beat.
  assign prea_bit = |(cPREAMBLE & (cPREA_LEN'(1) << pcnt_q));
  assign ld_bit   = in_acc ? idat : prea_bit;

  pack_sym_map #(
    .SYM_ONE  (SYM_ONE),
    .SYM_ZERO (SYM_ZERO)
  ) u_sym_map (
    .bit_i (ld_bit),
    .sym_o (ld_sym)
  );

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      dcnt_q  <= '0;
      gcnt_q  <= '0;
      oval_q  <= 1'b0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      odat_q  <= '0;
    end else begin
      if (in_acc) begin
        odat_q <= ld_sym;
        oval_q <= 1'b1;
        oeop_q <= pay_last;
        if (!pay_last) dcnt_q <= dcnt_q + DCW'(1);
      end
      case (state_q)
        IDLE: begin
          if (istart) begin
            odat_q  <= ld_sym;
            oval_q  <= 1'b1;
            osop_q  <= 1'b1;
            pcnt_q  <= PCW'(1);
            state_q <= PREA;
          end else begin
            oval_q <= 1'b0;
          end
        end
        PREA: begin
          if (out_acc) begin
            osop_q <= 1'b0;
            if (pcnt_q < PREA_END) begin
              odat_q <= ld_sym;
              pcnt_q <= pcnt_q + PCW'(1);
            end else begin
              state_q <= PAY;
              if (!in_acc) oval_q <= 1'b0;
            end
          end
        end
        PAY: begin
          if (out_acc && !in_acc) begin
            oval_q <= 1'b0;
            if (oeop_q) begin
              oeop_q  <= 1'b0;
              pcnt_q  <= '0;
              dcnt_q  <= '0;
              gcnt_q  <= '0;
              state_q <= (GAP_LEN == 0) ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          if (gcnt_q == GAP_LAST) state_q <= IDLE;
          else                    gcnt_q  <= gcnt_q + GCW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oval  = oval_q;
  assign osop  = osop_q;
  assign oeop  = oeop_q;
  assign odat  = odat_q;
  assign obusy = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pack_framer.sv
// ------------------------------------------------------------------------
// tb_pack_framer : scoreboard bench for pack_framer (PAYLOAD_LEN 8, GAP_LEN 16). rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_pack_framer;
  import pack_pkg::*;

  localparam int PL    = 8;
  localparam int GL    = 16;
  localparam int FRAME = cPREA_LEN + PL;

  logic       clk    = 1'b0;
  logic       irst   = 1'b1;
  logic       istart = 1'b0;
  logic       idat   = 1'b0;
  logic       ival   = 1'b0;
  logic       irdy   = 1'b1;
  logic       ordy;
  logic       oval;
  logic       osop;
  logic       oeop;
  logic [4:0] odat;
  logic       obusy;

  pack_framer #(
    .PREA_LEN    (cPREA_LEN),
    .PAYLOAD_LEN (PL),
    .GAP_LEN     (GL)
  ) dut (
    .iclk   (clk),
    .irst   (irst),
    .istart (istart),
    .idat   (idat),
    .ival   (ival),
    .ordy   (ordy),
    .irdy   (irdy),
    .oval   (oval),
    .osop   (osop),
    .oeop   (oeop),
    .odat   (odat),
    .obusy  (obusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sym;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic [cPREA_LEN-1:0] prea = cPREAMBLE;

  function automatic logic [4:0] bmap(input logic b);
    return b ? 5'h0F : 5'h10;
  endfunction

  // Upstream source
  logic [0:PL-1] src_bits   = '0;
  int            src_idx    = PL;
  bit            bp_en      = 1'b0;
  int            starve_at  = -1;
  int            starve_left = 0;
  bit            in_take    = 1'b0;

  always @(posedge clk) begin
    if (in_take) src_idx++;
    #1;
    if (starve_at == src_idx && starve_left > 0) begin
      ival = 1'b0;
      starve_left--;
    end else begin
      ival = (src_idx < PL);
    end
    idat = (src_idx < PL) ? src_bits[src_idx] : 1'b0;
    irdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor / scoreboard
  bit         hold_prev = 1'b0;
  logic [4:0] h_odat;
  logic       h_sop, h_eop;
  int         beats = 0, nsop = 0, neop = 0, bubbles = 0, holds = 0;
  bit         in_frame = 1'b0, eop_seen = 1'b0;
  bit         gap_counting = 1'b0;
  int         since_eop = 0, gap_meas = -1;
  logic [4:0] rx_log[$];

  always @(negedge clk) begin
    in_take = !irst && ival && ordy;
    if (irst) begin
      hold_prev    = 1'b0;
      in_frame     = 1'b0;
      gap_counting = 1'b0;
    end else begin
      if (hold_prev) begin
        n_checks++;
        if (oval !== 1'b1 || odat !== h_odat || osop !== h_sop || oeop !== h_eop) begin
          n_fail++;
          $display("FAIL hold_stable: got oval=%b odat=%h sop=%b eop=%b, required oval=1 odat=%h sop=%b eop=%b",
                   oval, odat, osop, oeop, h_odat, h_sop, h_eop);
        end
      end
      hold_prev = oval && !irdy;
      h_odat = odat; h_sop = osop; h_eop = oeop;
      if (hold_prev) holds++;

      if (gap_counting) begin
        if (oval) begin
          gap_meas     = since_eop;
          gap_counting = 1'b0;
        end else begin
          since_eop++;
        end
      end

      if (oval && irdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got odat=%h sop=%b eop=%b, required no beat", odat, osop, oeop);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (odat !== e.sym || osop !== e.sop || oeop !== e.eop) begin
            n_fail++;
            $display("FAIL beat_%0d: got odat=%h sop=%b eop=%b, required odat=%h sop=%b eop=%b",
                     beats, odat, osop, oeop, e.sym, e.sop, e.eop);
          end
        end
        beats++;
        rx_log.push_back(odat);
        if (osop) begin nsop++; in_frame = 1'b1; end
        if (oeop) begin
          neop++;
          in_frame     = 1'b0;
          eop_seen     = 1'b1;
          gap_counting = 1'b1;
          since_eop    = 0;
        end
      end else if (in_frame && !oval) begin
        bubbles++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers (no comparisons inside)
  task automatic push_frame(input logic [0:PL-1] pay);
    beat_t b;
    for (int i = 0; i < cPREA_LEN; i++) begin
      b.sym = bmap(prea[i]); b.sop = (i == 0); b.eop = 1'b0;
      exp_q.push_back(b);
    end
    for (int j = 0; j < PL; j++) begin
      b.sym = bmap(pay[j]); b.sop = 1'b0; b.eop = (j == PL - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic start_frame(input logic [0:PL-1] pay);
    int c = 0;
    while (obusy && c < 200) begin @(negedge clk); c++; end
    @(negedge clk);
    beats = 0; nsop = 0; neop = 0; bubbles = 0; holds = 0;
    eop_seen = 1'b0; gap_meas = -1;
    rx_log.delete();
    push_frame(pay);
    src_bits = pay;
    src_idx  = 0;
    istart   = 1'b1;
    @(negedge clk);
    istart   = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    int c = 0;
    while ((exp_q.size() != 0 || !eop_seen) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    ok = (exp_q.size() == 0) && eop_seen;
  endtask

  // Tests
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({oval, osop, oeop, ordy, obusy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got {oval,osop,oeop,ordy,obusy}=%b, required 00000", {oval, osop, oeop, ordy, obusy});
    end
    n_checks++;
    if (odat !== 5'h00) begin
      n_fail++;
      $display("FAIL reset_odat: got %h, required 00", odat);
    end
    @(posedge clk);
    #2 irst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (oval !== 1'b0 || obusy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got oval=%b obusy=%b, required 0 0", oval, obusy);
    end
  endtask

  task automatic test_basic;
    bit ok;
    start_frame(8'b10110010);
    wait_done(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done: got %0d beats pending, required 0", exp_q.size()); end
    n_checks++;
    if (beats != FRAME) begin n_fail++; $display("FAIL basic_beats: got %0d, required %0d", beats, FRAME); end
    n_checks++;
    if (bubbles != 0) begin n_fail++; $display("FAIL basic_bubbles: got %0d, required 0", bubbles); end
    n_checks++;
    if (nsop != 1 || neop != 1) begin n_fail++; $display("FAIL basic_sop_eop: got %0d/%0d, required 1/1", nsop, neop); end
  endtask

  task automatic test_loopback;
    bit hb[0:FRAME-1];
    int det = 0;
    int det_k = -1;
    n_checks++;
    if (rx_log.size() != FRAME) begin
      n_fail++;
      $display("FAIL loop_len: got %0d, required %0d", rx_log.size(), FRAME);
    end else begin
      for (int i = 0; i < FRAME; i++) hb[i] = ~rx_log[i][4];
      for (int i = 0; i < 20; i++) hb[i * 6 + 3] = ~hb[i * 6 + 3];
      for (int k = cPREA_LEN - 1; k < FRAME; k++) begin
        int m = 0;
        for (int j = 0; j < cPREA_LEN; j++)
          if (hb[k - cPREA_LEN + 1 + j] == prea[j]) m++;
        if (m >= 100) begin det++; det_k = k; end
      end
      n_checks++;
      if (det != 1) begin n_fail++; $display("FAIL loop_count: got %0d detections, required 1", det); end
      n_checks++;
      if (det_k != cPREA_LEN - 1) begin n_fail++; $display("FAIL loop_align: got beat %0d, required %0d", det_k, cPREA_LEN - 1); end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bp_en = 1'b1;
    start_frame(8'b10110010);
    wait_done(3000, ok);
    bp_en = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_done: got %0d beats pending, required 0", exp_q.size()); end
    n_checks++;
    if (beats != FRAME || nsop != 1 || neop != 1) begin
      n_fail++;
      $display("FAIL bp_counts: got beats=%0d sop=%0d eop=%0d, required %0d 1 1", beats, nsop, neop, FRAME);
    end
    n_checks++;
    if (holds == 0) begin n_fail++; $display("FAIL bp_holds: got 0 stall cycles, required >0"); end
  endtask

  task automatic test_starvation;
    bit ok;
    starve_at   = 3;
    starve_left = 5;
    start_frame(8'b01101001);
    wait_done(400, ok);
    starve_at = -1;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL starve_done: got %0d beats pending, required 0", exp_q.size()); end
    n_checks++;
    if (bubbles == 0) begin n_fail++; $display("FAIL starve_bubbles: got 0, required >0"); end
    n_checks++;
    if (beats != FRAME || neop != 1) begin
      n_fail++;
      $display("FAIL starve_counts: got beats=%0d eop=%0d, required %0d 1", beats, neop, FRAME);
    end
  endtask

  task automatic test_istart_ignored;
    bit ok;
    int c;
    start_frame(8'b11001010);
    push_frame(8'b01001101);
    c = 0;
    while (beats < 10 && c < 100) begin @(negedge clk); c++; end
    istart = 1'b1;
    n_checks++;
    if (obusy !== 1'b1) begin n_fail++; $display("FAIL busy_prea: got %b, required 1", obusy); end
    @(negedge clk);
    istart = 1'b0;
    c = 0;
    while (beats < cPREA_LEN + 3 && c < 300) begin @(negedge clk); c++; end
    istart = 1'b1;
    n_checks++;
    if (obusy !== 1'b1) begin n_fail++; $display("FAIL busy_pay: got %b, required 1", obusy); end
    @(negedge clk);
    istart = 1'b0;
    c = 0;
    while (!eop_seen && c < 100) begin @(negedge clk); c++; end
    src_bits = 8'b01001101;
    src_idx  = 0;
    istart   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obusy !== 1'b1) begin n_fail++; $display("FAIL busy_gap: got %b, required 1", obusy); end
    c = 0;
    while (nsop < 2 && c < 100) begin @(negedge clk); c++; end
    istart = 1'b0;
    n_checks++;
    if (gap_meas != GL + 1) begin
      n_fail++;
      $display("FAIL gap_len: got %0d idle cycles, required %0d", gap_meas, GL + 1);
    end
    wait_done(400, ok);
    n_checks++;
    if (!ok || nsop != 2 || neop != 2) begin
      n_fail++;
      $display("FAIL istart_frames: got sop=%0d eop=%0d pending=%0d, required 2 2 0", nsop, neop, exp_q.size());
    end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int c = 0;
    start_frame(8'b10011110);
    while (beats < 60 && c < 200) begin @(negedge clk); c++; end
    @(posedge clk);
    #2 irst = 1'b1;
    #1;
    n_checks++;
    if ({oval, osop, oeop, ordy, obusy} !== 5'b0 || odat !== 5'h00) begin
      n_fail++;
      $display("FAIL async_reset: got ctrl=%b odat=%h, required 00000 00", {oval, osop, oeop, ordy, obusy}, odat);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 irst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (neop != 0 || oval !== 1'b0 || obusy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got eop=%0d oval=%b obusy=%b, required 0 0 0", neop, oval, obusy);
    end
    start_frame(8'b00110101);
    wait_done(400, ok);
    n_checks++;
    if (!ok || beats != FRAME || nsop != 1 || neop != 1) begin
      n_fail++;
      $display("FAIL post_reset_frame: got beats=%0d sop=%0d eop=%0d, required %0d 1 1", beats, nsop, neop, FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_backpressure();
    test_starvation();
    test_istart_ignored();
    test_reset_midframe();
    repeat (GL + 4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
